r5p_hpm: RTL
============

// Module: r5p_hpm
// PURPOSE
//   Parametrised hardware performance monitor for R5P cores.
//   - Holds mcycle, minstret, CNT programmable mhpmcounterN with mhpmeventN selectors, and mcountinhibit.
//   - Adds split lo/hi access for counters wider than XLEN, a per-counter overflow flag and a level overflow interrupt.
//   - Sits beside the CSR file: it decodes its own CSR addresses and returns read data plus a hit flag for the read mux.
// PARAMETERS
//   XLEN    32  register width; 32 or 64
//   CNT     29  number of programmable counters, 0..29 (mhpmcounter3..mhpmcounter[2+CNT])
//   CW      64  counter width; XLEN < CW <= 2*XLEN implements *h registers, CW <= XLEN omits them
//   EVENTS  16  width of the event vector, <= XLEN-1
// PORTS
//   clk        in   1       clock
//   rst        in   1       reset, synchronous, active-high
//   csr_adr    in   12      CSR address
//   csr_ren    in   1       CSR read strobe
//   csr_wen    in   1       CSR write strobe; csr_wdt is the final RW/RS/RC result
//   csr_wdt    in   XLEN    CSR write data
//   csr_rdt    out  XLEN    read data; 0 when no hit or csr_ren=0
//   csr_hit    out  1       csr_adr is decoded by this block
//   cycle_i    in   1       cycle event
//   instret_i  in   1       instruction-retired event
//   event_i    in   EVENTS  programmable event sources
//   irq_o      out  1       overflow interrupt, level
// BEHAVIOUR
//   Reset (rst=1 at posedge): all counters, mhpmevent and mcountinhibit are 0. irq_o=0 next cycle. csr_rdt and csr_hit are combinational.
//   Address map
//   - mcycle B00/B80h, minstret B02/B82h, mhpmcounterN B00+N / B80+N.
//   - mhpmeventN 320+N, mcountinhibit 320.
//   - Read-only aliases C00..C1F / C80..C9F; writes to them are ignored.
//   - B01/B81/C01/C81 (time) are not hit.
//   - Counters with N >= 3+CNT: hit=1, read 0, writes ignored.
//   mcountinhibit
//   - bit0 CY, bit2 IR, bit N HPMN.
//   - bit1 and unimplemented bits read 0 and are not writable.
//   Increment
//   - mcycle: +1 when cycle_i & ~CY. minstret: +1 when instret_i & ~IR.
//   - mhpmcounterN: +1 when ~HPMN & |(event_i & mhpmeventN[EVENTS-1:0]).
//   - Step is at most 1 per cycle. The full CW-bit count, with carry across the lo/hi halves, happens in the same cycle.
//   Write
//   - A write to either half of a counter loads that half; the other half holds. That counter does not increment in that cycle.
//   - Hi bits above CW-XLEN read 0.
//   - Written value is visible on a read the next cycle.
//   Overflow
//   - Applies to programmable counters only.
//   - An increment from all-ones (CW bits) to 0 sets mhpmeventN.OF (bit XLEN-1).
//   - OF is cleared only by a CSR write of mhpmeventN with bit XLEN-1=0.
//   - Overflow in the same cycle as such a write leaves OF=1 (set wins).
//   - mhpmeventN bits XLEN-2..EVENTS read 0.
//   irq_o
//   - Registered: irq_o = |OF, one cycle after OF changes.
//   - Inhibiting a counter does not clear OF.
//   Reset mid-operation
//   - rst overrides any same-cycle write or increment.
// TESTING
//   T1 rst, then cycle_i=1 for 10 clocks, CY=0 -> mcycle reads 10, mcycleh 0; all mhpmevent and irq_o 0.
//   T2 XLEN=32: write mcycle=FFFF_FFFE, then 3 cycle_i pulses -> mcycle=1, mcycleh=1 (carry in same cycle as lo wrap).
//   T3 mhpmevent3=0x5, pulse event_i=0x4, 0x8, 0x1 -> mhpmcounter3=2; set mcountinhibit bit3, pulse 0x1 -> stays 2.
//   T4 mhpmcounter4 = all-ones (lo and hi), mhpmevent4=0x1, pulse event_i[0] -> counter 0, OF=1, irq_o=1 next cycle; write mhpmevent4=0x1 -> irq_o=0 one cycle later.
//   T5 write mhpmcounter5 while its event fires -> read back equals written value (no +1); write C03 -> no change; read C03 equals B03.
//   T6 CNT=4: read B0A -> hit=1, 0; write mcountinhibit=FFFF_FFFF -> reads 0000_007D; rst during a write -> all registers 0.

Source files
------------

// File: rtl/r5p_hpm.sv
// r5p_hpm - hardware performance monitor for R5P cores.
//
// Holds mcycle, minstret, CNT programmable mhpmcounterN with mhpmeventN
// selectors, and mcountinhibit. Counters wider than XLEN are exposed as split
// lo/hi CSRs. Each programmable counter has an overflow flag (mhpmeventN
// bit XLEN-1). The OR of all overflow flags drives a level interrupt.
// The block decodes its own CSR addresses and sits beside the CSR file.
//
// Ports
//   clk        clock
//   rst        synchronous, active-high reset
//   csr_adr    CSR address (12 bits)
//   csr_ren    CSR read strobe
//   csr_wen    CSR write strobe; csr_wdt already holds the final RW/RS/RC value
//   csr_wdt    CSR write data (XLEN)
//   csr_rdt    CSR read data (XLEN); 0 when there is no hit or csr_ren=0
//   csr_hit    csr_adr is decoded by this block (combinational)
//   cycle_i    cycle event
//   instret_i  instruction-retired event
//   event_i    programmable event sources (EVENTS)
//   irq_o      registered overflow interrupt, level
module r5p_hpm #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CNT    = 29,
  parameter int unsigned CW     = 64,
  parameter int unsigned EVENTS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [11:0]       csr_adr,
  input  logic              csr_ren,
  input  logic              csr_wen,
  input  logic [XLEN-1:0]   csr_wdt,
  output logic [XLEN-1:0]   csr_rdt,
  output logic              csr_hit,
  input  logic              cycle_i,
  input  logic              instret_i,
  input  logic [EVENTS-1:0] event_i,
  output logic              irq_o
);

  // Index one past the last implemented counter (mcycle=0, minstret=2, hpm 3..)
  localparam int unsigned NC     = 3 + CNT;
  localparam bit          HAS_HI = (CW > XLEN);
  // Writable mcountinhibit bits: CY, IR and one per implemented hpm counter
  localparam logic [31:0] INH_MASK =
    32'h5 | ((CNT == 0) ? 32'h0 : (((32'h1 << CNT) - 32'h1) << 3));

  // Address decode
  logic [4:0] idx;
  logic       sel_mlo, sel_mhi, sel_ulo, sel_uhi, sel_evt;
  logic       ctr_lo, ctr_hi, evt_hit;

  assign idx     = csr_adr[4:0];
  assign sel_mlo = (csr_adr[11:5] == 7'h58);  // B00..B1F
  assign sel_mhi = (csr_adr[11:5] == 7'h5C);  // B80..B9F
  assign sel_ulo = (csr_adr[11:5] == 7'h60);  // C00..C1F, read-only alias
  assign sel_uhi = (csr_adr[11:5] == 7'h64);  // C80..C9F, read-only alias
  assign sel_evt = (csr_adr[11:5] == 7'h19);  // 320..33F

  // Index 1 is the time CSR, owned elsewhere
  assign ctr_lo  = (sel_mlo || sel_ulo) && (idx != 5'd1);
  assign ctr_hi  = HAS_HI && (sel_mhi || sel_uhi) && (idx != 5'd1);
  // 321/322 have no mhpmevent behind them
  assign evt_hit = sel_evt && ((idx == 5'd0) || (idx >= 5'd3));
  assign csr_hit = ctr_lo || ctr_hi || evt_hit;

  // mcountinhibit
  logic [31:0] inh_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      inh_q <= '0;
    end else if (csr_wen && sel_evt && (idx == 5'd0)) begin
      inh_q <= csr_wdt[31:0] & INH_MASK;
    end
  end

  // Per-index views; unimplemented indices are tied to zero
  logic [2*XLEN-1:0] cnt_ext [32];
  logic [EVENTS-1:0] sel_v   [32];
  logic [XLEN-1:0]   evt_rd  [32];
  logic              ovf_v   [32];
  logic              of_v    [32];

  // Counters
  for (genvar i = 0; i < 32; i++) begin : g_ctr
    if ((i == 0) || ((i >= 2) && (i < NC))) begin : g_on
      logic [CW-1:0]     cnt_q;
      logic [2*XLEN-1:0] cur;
      logic [2*XLEN-1:0] nxt;
      logic              wr_lo;
      logic              wr_hi;
      logic              inc;

      assign cur   = (2*XLEN)'(cnt_q);
      assign wr_lo = csr_wen && sel_mlo && (idx == 5'(i));
      assign wr_hi = csr_wen && sel_mhi && (idx == 5'(i)) && HAS_HI;

      if (i == 0) begin : g_cy
        assign inc = cycle_i & ~inh_q[0];
      end else if (i == 2) begin : g_ir
        assign inc = instret_i & ~inh_q[2];
      end else begin : g_hpm
        assign inc = ~inh_q[i] & (|(event_i & sel_v[i]));
      end

      // A write to either half wins over the increment; the full-width add
      // carries across the lo/hi boundary in the same cycle
      always_comb begin
        nxt = cur;
        if (wr_lo) begin
          nxt[XLEN-1:0] = csr_wdt;
        end else if (wr_hi) begin
          nxt[2*XLEN-1:XLEN] = csr_wdt;
        end else if (inc) begin
          nxt = cur + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= CW'(nxt);
        end
      end

      assign cnt_ext[i] = cur;
      // Only programmable counters report overflow
      assign ovf_v[i]   = (i >= 3) ? (inc & ~wr_lo & ~wr_hi & (&cnt_q)) : 1'b0;
    end else begin : g_off
      assign cnt_ext[i] = '0;
      assign ovf_v[i]   = 1'b0;
    end
  end

  // Event selectors and overflow flags
  for (genvar i = 0; i < 32; i++) begin : g_evt
    if ((i >= 3) && (i < NC)) begin : g_on
      logic [EVENTS-1:0] sel_q;
      logic              of_q;
      logic              wr;

      assign wr = csr_wen && sel_evt && (idx == 5'(i));

      // Overflow in the same cycle as a clearing write keeps OF set
      always_ff @(posedge clk) begin
        if (rst) begin
          sel_q <= '0;
          of_q  <= 1'b0;
        end else begin
          if (wr) begin
            sel_q <= csr_wdt[EVENTS-1:0];
            of_q  <= csr_wdt[XLEN-1] | ovf_v[i];
          end else begin
            of_q  <= of_q | ovf_v[i];
          end
        end
      end

      assign sel_v[i]  = sel_q;
      assign of_v[i]   = of_q;
      assign evt_rd[i] = {of_q, (XLEN-1)'(sel_q)};
    end else begin : g_off
      assign sel_v[i]  = '0;
      assign of_v[i]   = 1'b0;
      assign evt_rd[i] = '0;
    end
  end

  // Read mux
  logic [XLEN-1:0] rd_val;

  always_comb begin
    rd_val = '0;
    if (ctr_lo) begin
      rd_val = cnt_ext[idx][XLEN-1:0];
    end else if (ctr_hi) begin
      rd_val = cnt_ext[idx][2*XLEN-1:XLEN];
    end else if (evt_hit) begin
      rd_val = (idx == 5'd0) ? XLEN'(inh_q) : evt_rd[idx];
    end
  end

  assign csr_rdt = (csr_ren && csr_hit) ? rd_val : '0;

  // Interrupt stage: OR of overflow flags, registered
  logic of_any;
  logic irq_p1;

  always_comb begin
    of_any = 1'b0;
    for (int i = 0; i < 32; i++) begin
      of_any = of_any | of_v[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_p1 <= 1'b0;
    end else begin
      irq_p1 <= of_any;
    end
  end

  assign irq_o = irq_p1;

endmodule
